// File: rtl/grayscale_stream_ctrl.sv
// grayscale_stream_ctrl: RGB565 -> 8-bit grayscale streaming controller.
// Each 32-bit input word carries two RGB565 pixels, and both are converted in parallel.
// Four grayscale bytes are packed into each 32-bit output word.
// Optional build macro GRAY_LITTLE_ENDIAN_EN swaps pixel and byte ordering
// to little-endian. Handshake, counting and timing are unchanged.

// Per-pixel converter: gray = (54*R + 183*G + 19*B)[15:8], 16-bit unsigned, truncated.
module gray_lane (
  input  logic [15:0] pix,
  output logic [7:0]  gray
);
  logic [15:0] sum;

  // Weighted sum of the RGB565 fields. The maximum is 0x35E0, so it fits in 16 bits.
  always_comb begin
    sum = 16'd54  * {11'd0, pix[15:11]}
        + 16'd183 * {10'd0, pix[10:5]}
        + 16'd19  * {11'd0, pix[4:0]};
  end

  assign gray = 8'(sum >> 8);
endmodule

module grayscale_stream_ctrl #(
  parameter int CNT_WIDTH = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] pixel_count,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  input  logic [31:0]          in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [31:0]          out_data,
  input  logic                 out_ready
);
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                         state, state_nxt;
  logic [CNT_WIDTH-1:0]           pix_left, pix_left_nxt;
  logic                           half;
  logic [NUM_LANES-1:0][7:0]      pack;        // pack[0] = first pixel's byte
  logic                           done_q;
  logic                           out_valid_q;
  logic [31:0]                    out_data_q;

  logic [NUM_LANES-1:0][15:0]     lane_pix;    // lane 0 = pixel0
  logic [NUM_LANES-1:0][7:0]      lane_gray;
  logic [NUM_LANES-1:0][7:0]      new_bytes;

  logic in_ready_c, accept, load_word, load_flush, done_set, out_free;

  // Pixel ordering within the input word
`ifdef GRAY_LITTLE_ENDIAN_EN
  assign lane_pix = {in_data[31:16], in_data[15:0]};
`else
  assign lane_pix = {in_data[15:0], in_data[31:16]};
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    gray_lane u_lane (.pix(lane_pix[i]), .gray(lane_gray[i]));
  end

  // Byte k in stream order goes to its output position. Stream order is b0..b3.
  function automatic logic [31:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
`ifdef GRAY_LITTLE_ENDIAN_EN
    return {b3, b2, b1, b0};
`else
    return {b0, b1, b2, b3};
`endif
  endfunction

  // If only one pixel is left, the second pixel in the word is padding and its byte is forced to 0.
  always_comb begin
    new_bytes[0] = lane_gray[0];
    new_bytes[1] = (pix_left == CNT_WIDTH'(1)) ? 8'h00 : lane_gray[1];
  end

  // Remaining pixel count after an accept: subtract min(2, pix_left).
  always_comb begin
    pix_left_nxt = pix_left - ((pix_left >= CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : pix_left);
  end

  assign out_free = !out_valid_q || out_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (pixel_count == '0) ? DONE : RUN;
      RUN:   if (accept && pix_left_nxt == '0) state_nxt = half ? DONE : FLUSH;
      FLUSH: if (out_free) state_nxt = DONE;
      DONE:  if (done_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs. In RUN, a half-filled pack can always take a word. A full pack needs the output slot free.
  always_comb begin
    in_ready_c = 1'b0;
    load_flush = 1'b0;
    done_set   = 1'b0;
    case (state)
      RUN:   in_ready_c = !half || out_free;
      FLUSH: load_flush = out_free;
      DONE:  done_set   = !done_q && out_free;
      default: ;
    endcase
  end

  assign accept    = in_valid && in_ready_c;
  assign load_word = accept && half;

  // Datapath: counters, pack register, output word register and done pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_left    <= '0;
      half        <= 1'b0;
      pack        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= done_set;
      if (state == IDLE && start) begin
        pix_left <= pixel_count;
        half     <= 1'b0;
      end
      if (accept) begin
        pix_left <= pix_left_nxt;
        half     <= !half;
        if (!half) pack <= new_bytes;
      end
      if (load_word) begin
        out_data_q  <= pack_word(pack[0], pack[1], new_bytes[0], new_bytes[1]);
        out_valid_q <= 1'b1;
      end else if (load_flush) begin
        out_data_q  <= pack_word(pack[0], pack[1], 8'h00, 8'h00);
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule
